usb_kbd_events: RTL and testbench

- Sits in the `clk` domain of the SoC, directly downstream of the USB HID host.
- Takes 8-byte boot-protocol keyboard reports and diffs each new report against the previous one.
- Emits discrete press/release events for keys and modifiers into a FIFO that the CPU pops over the peripheral bus.
- Replaces raw-report polling with an event stream, matching the PS/2 code/strobe path.

---
 rtl/usb_kbd_pkg.sv | 58 +++++
 rtl/usb_kbd_fifo.sv | 49 ++++
 rtl/usb_kbd_events.sv | 190 +++++++++++++++++++
 tb/tb_usb_kbd_events.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_kbd_pkg.sv
// usb_kbd_pkg: shared types, usage constants and report helpers for the
// USB boot-keyboard event scanner.
package usb_kbd_pkg;

    localparam int REPORT_BYTES = 8;
    localparam int KEY_BASE     = 2;  // first usage byte in the report
    localparam int KEY_SLOTS    = 6;

    localparam logic [7:0] USAGE_NONE     = 8'h00;
    localparam logic [7:0] USAGE_ROLLOVER = 8'h01;
    localparam logic [7:0] USAGE_MOD_BASE = 8'hE0;

    typedef struct packed {
        logic       pressed;
        logic [7:0] usage;
    } kbd_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOD,
        ST_REL,
        ST_PRS,
        ST_COMMIT
    } scan_state_t;

    // Usage byte held in key slot s (0..5).
    function automatic logic [7:0] slot(input logic [8*REPORT_BYTES-1:0] r, input int s);
        return r[8*(s+KEY_BASE) +: 8];
    endfunction

    // True when usage u sits in any key slot of r.
    function automatic logic has_usage(input logic [8*REPORT_BYTES-1:0] r, input logic [7:0] u);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < KEY_SLOTS; s++)
            if (slot(r, s) == u) hit = 1'b1;
        return hit;
    endfunction

    // True when slot s is the first occurrence of its usage, so duplicates act as one key.
    function automatic logic first_use(input logic [8*REPORT_BYTES-1:0] r, input int s);
        logic dup;
        dup = 1'b0;
        for (int j = 0; j < KEY_SLOTS; j++)
            if (j < s && slot(r, j) == slot(r, s)) dup = 1'b1;
        return !dup;
    endfunction

    // Phantom-state report: every key slot reports ErrorRollOver.
    function automatic logic is_rollover(input logic [8*REPORT_BYTES-1:0] r);
        logic all;
        all = 1'b1;
        for (int s = 0; s < KEY_SLOTS; s++)
            if (slot(r, s) != USAGE_ROLLOVER) all = 1'b0;
        return all;
    endfunction

endpackage

// File: rtl/usb_kbd_fifo.sv
// usb_kbd_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module usb_kbd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop_ok, push_ok;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    // Hold the head at zero while empty so nothing stale is presented.
    assign head    = valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/usb_kbd_events.sv
// usb_kbd_events: diffs successive HID boot keyboard reports and queues
// press/release events for the CPU. Optional auto-repeat is enabled by
// defining USB_KBD_REPEAT_EN.
module usb_kbd_events
    import usb_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                          clk,
    input  logic                          reset_n_i,
    input  logic [63:0]                   usb_report_i,
    input  logic                          usb_report_valid_i,
    input  logic                          evt_rd_i,
    output logic [8:0]                    evt_data_o,
    output logic                          evt_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
    output logic                          busy_o
);
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("usb_kbd_events: illegal parameter set");
    end

    logic [2:0]   sync_q;
    logic         rpt_edge;
    logic [63:0]  pend, cur, prev;
    logic         pend_vld;
    scan_state_t  state;
    logic [2:0]   idx;
    logic         step_emit, fifo_full, fifo_ready, scan_push, stall;
    kbd_event_t   step_evt, push_evt;
    logic         rpt_fire;
    kbd_event_t   rpt_evt;

    assign rpt_edge = sync_q[1] & ~sync_q[2];
    assign busy_o   = (state != ST_IDLE);

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) sync_q <= '0;
        else            sync_q <= {sync_q[1:0], usb_report_valid_i};
    end

    // Pending slot: newest report wins; a capture beats a same-cycle consume.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (rpt_edge) begin
            pend     <= usb_report_i;
            pend_vld <= 1'b1;
        end else if (state == ST_IDLE) begin
            pend_vld <= 1'b0;
        end
    end

    // Decide whether the current scan step produces an event.
    always_comb begin
        step_emit = 1'b0;
        step_evt  = '0;
        case (state)
            ST_MOD: begin
                step_emit = prev[idx] != cur[idx];
                step_evt  = '{pressed: cur[idx], usage: USAGE_MOD_BASE | {5'b0, idx}};
            end
            ST_REL: begin
                step_evt  = '{pressed: 1'b0, usage: slot(prev, int'(idx))};
                step_emit = step_evt.usage != USAGE_NONE && first_use(prev, int'(idx)) &&
                            !has_usage(cur, step_evt.usage);
            end
            ST_PRS: begin
                step_evt  = '{pressed: 1'b1, usage: slot(cur, int'(idx))};
                step_emit = step_evt.usage != USAGE_NONE && first_use(cur, int'(idx)) &&
                            !has_usage(prev, step_evt.usage);
            end
            default: ;
        endcase
    end

    assign fifo_ready = !fifo_full || evt_rd_i;
    assign stall      = step_emit && !fifo_ready;
    assign scan_push  = step_emit && fifo_ready;
    assign push_evt   = rpt_fire ? rpt_evt : step_evt;

    // Scanner: modifiers, then releases, then presses, then commit.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            cur   <= '0;
            prev  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (pend_vld && !is_rollover(pend)) begin
                        cur   <= pend;
                        state <= ST_MOD;
                    end
                end
                ST_MOD: if (!stall) begin
                    idx <= idx + 1'b1;
                    if (idx == 3'd7) begin
                        idx   <= '0;
                        state <= ST_REL;
                    end
                end
                ST_REL: if (!stall) begin
                    idx <= idx + 1'b1;
                    if (idx == 3'd5) begin
                        idx   <= '0;
                        state <= ST_PRS;
                    end
                end
                ST_PRS: if (!stall) begin
                    idx <= idx + 1'b1;
                    if (idx == 3'd5) begin
                        idx   <= '0;
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    prev  <= cur;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef USB_KBD_REPEAT_EN
    logic [7:0]  rpt_key, rpt_last;
    logic        rpt_on, rpt_new;
    logic [31:0] rpt_cnt;

    assign rpt_evt  = '{pressed: 1'b1, usage: rpt_key};
    assign rpt_fire = rpt_on && rpt_cnt == '0 && state == ST_IDLE && !fifo_full;

    // Auto-repeat timer: armed by the last new key press, cancelled on its release.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rpt_key  <= '0;
            rpt_last <= '0;
            rpt_on   <= 1'b0;
            rpt_new  <= 1'b0;
            rpt_cnt  <= '0;
        end else begin
            if (state == ST_PRS && scan_push && step_evt.usage < USAGE_MOD_BASE) begin
                rpt_last <= step_evt.usage;
                rpt_new  <= 1'b1;
            end
            if (state == ST_COMMIT) begin
                rpt_new <= 1'b0;
                if (rpt_new) begin
                    rpt_key <= rpt_last;
                    rpt_on  <= 1'b1;
                    rpt_cnt <= 32'(REPEAT_DELAY - 1);
                end else if (rpt_on && !has_usage(cur, rpt_key)) begin
                    rpt_on <= 1'b0;
                end
            end else if (rpt_on) begin
                // A missed slot (scan busy or FIFO full) is skipped, not queued.
                if (rpt_cnt == '0) rpt_cnt <= 32'(REPEAT_PERIOD - 1);
                else               rpt_cnt <= rpt_cnt - 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
    assign rpt_evt  = '0;
`endif

    usb_kbd_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n_i),
        .push      (scan_push | rpt_fire),
        .push_data (push_evt),
        .pop       (evt_rd_i),
        .head      (evt_data_o),
        .valid     (evt_valid_o),
        .full      (fifo_full),
        .count     (evt_count_o)
    );

endmodule

// File: tb/tb_usb_kbd_events.sv
// tb_usb_kbd_events: scoreboard bench for the keyboard event scanner,
// built with a 4-entry FIFO so the backpressure stall is reachable.
module tb_usb_kbd_events;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [63:0] usb_report_i = '0;
    logic        usb_report_valid_i = 1'b0;
    logic        evt_rd_i = 1'b0;
    logic [8:0]  evt_data_o;
    logic        evt_valid_o;
    logic [2:0]  evt_count_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    usb_kbd_events #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .reset_n_i          (reset_n_i),
        .usb_report_i       (usb_report_i),
        .usb_report_valid_i (usb_report_valid_i),
        .evt_rd_i           (evt_rd_i),
        .evt_data_o         (evt_data_o),
        .evt_valid_o        (evt_valid_o),
        .evt_count_o        (evt_count_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                                       input logic [7:0] f);
        return {f, e, d, c, b, a, 8'h00, m};
    endfunction

    task automatic send(input logic [63:0] r);
        @(posedge clk); #1;
        usb_report_i       = r;
        usb_report_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 usb_report_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    // Pop events as they appear and compare each against the scoreboard head.
    task automatic drain(input string tag);
        int idle;
        idle = 0;
        while (exp_q.size() > 0 && idle < 200) begin
            @(negedge clk);
            if (evt_valid_o) begin
                chk(tag, 32'(evt_data_o), 32'(exp_q.pop_front()));
                evt_rd_i = 1'b1;
                @(posedge clk); #1;
                evt_rd_i = 1'b0;
            end else begin
                idle++;
            end
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_extra"}, 32'(evt_valid_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_count", 32'(evt_count_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_data",  32'(evt_data_o), 32'd0);

        // single key press then release
        exp_q.push_back(9'h104);
        send(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t1_idle");
        chk("t1_cnt_p", 32'(evt_count_o), 32'd1);
        drain("t1_press");
        exp_q.push_back(9'h004);
        send(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t1_idle2");
        chk("t1_cnt_r", 32'(evt_count_o), 32'd1);
        drain("t1_rel");

        // modifiers 0x00 -> 0x22 -> 0x00
        exp_q.push_back(9'h1E1);
        exp_q.push_back(9'h1E5);
        send(mk(8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t2_idle");
        drain("t2_mod");
        exp_q.push_back(9'h0E1);
        exp_q.push_back(9'h0E5);
        send(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t2_idle2");
        drain("t2_modrel");

        // {04,05} -> {05,06}
        exp_q.push_back(9'h104);
        exp_q.push_back(9'h105);
        send(mk(8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t3_idle");
        drain("t3_a");
        exp_q.push_back(9'h004);
        exp_q.push_back(9'h106);
        send(mk(8'h00, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t3_idle2");
        drain("t3_b");

        // {05,06} -> {04}, then rollover report is ignored
        exp_q.push_back(9'h005);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h104);
        send(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t4_idle");
        drain("t4_a");
        send(mk(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("t4_roll_busy", 32'(busy_o), 32'd0);
        chk("t4_roll_cnt",  32'(evt_count_o), 32'd0);
        exp_q.push_back(9'h004);
        send(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t4_idle2");
        drain("t4_b");

        // duplicate usage counts as one key
        exp_q.push_back(9'h107);
        send(mk(8'h00, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("dup_idle");
        drain("dup_p");
        exp_q.push_back(9'h007);
        send(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("dup_idle2");
        drain("dup_r");

        // six presses into a 4-deep FIFO: scanner stalls until popped
        for (int k = 4; k <= 9; k++) exp_q.push_back(9'h100 | 9'(k));
        send(mk(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t5_stall_busy", 32'(busy_o), 32'd1);
        chk("t5_stall_cnt",  32'(evt_count_o), 32'd4);
        drain("t5_press");
        wait_idle("t5_idle");
        for (int k = 4; k <= 9; k++) exp_q.push_back(9'(k));
        send(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        drain("t5_rel");
        wait_idle("t5_idle2");

        // reset while stalled in the press phase
        send(mk(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t6_stall_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        reset_n_i = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(evt_valid_o), 32'd0);
        chk("t6_rst_count", 32'(evt_count_o), 32'd0);
        chk("t6_rst_busy",  32'(busy_o), 32'd0);
        chk("t6_rst_data",  32'(evt_data_o), 32'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        exp_q.push_back(9'h104);
        send(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_idle("t6_idle");
        chk("t6_cnt", 32'(evt_count_o), 32'd1);
        drain("t6_press");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
